// File: rtl/alu_pkg.sv
// Shared widths, field layouts and entry type for the ALU issue buffer.
// The build-wide rename width lives here so every issue queue sees the same register map.
package alu_pkg;

    localparam int RNBIT  = 2;
    localparam int FUN_W  = 9;
    localparam int PR_W   = 5 + RNBIT;
    localparam int NPR    = 32 << RNBIT;

    localparam int DISP_W = FUN_W + 3 * PR_W + 64 + 3;
    localparam int EXEC_W = FUN_W + PR_W + 128 + 2;

    // LSB offsets of the dispatch-info fields
    localparam int D_USI  = 0;
    localparam int D_32W  = 1;
    localparam int D_IMMF = 2;
    localparam int D_IMM  = 3;
    localparam int D_RS2  = D_IMM + 64;
    localparam int D_RS1  = D_RS2 + PR_W;
    localparam int D_RD0  = D_RS1 + PR_W;
    localparam int D_FUN  = D_RD0 + PR_W;

    // LSB offsets of the execute-info fields
    localparam int X_USI  = 0;
    localparam int X_32W  = 1;
    localparam int X_OP2  = 2;
    localparam int X_OP1  = X_OP2 + 64;
    localparam int X_RD0  = X_OP1 + 64;
    localparam int X_FUN  = X_RD0 + PR_W;

    typedef logic [PR_W-1:0] preg_t;

    typedef struct packed {
        logic [FUN_W-1:0] fun;
        preg_t            rd0;
        preg_t            rs1;
        preg_t            rs2;
        logic [63:0]      imm;
        logic             rs2_is_imm;
        logic             is32w;
        logic             is_usi;
    } disp_info_t;

    typedef struct packed {
        logic [FUN_W-1:0] fun;
        preg_t            rd0;
        logic [63:0]      op1;
        logic [63:0]      op2;
        logic             is32w;
        logic             is_usi;
    } exec_info_t;

    typedef struct packed {
        logic       valid;
        disp_info_t op;
    } iq_entry_t;

    // Physical register 0 is hard-wired zero and therefore always available.
    function automatic logic reg_ok(input logic [NPR-1:0] wb, input preg_t r);
        return (r == '0) | wb[r];
    endfunction

endpackage

// File: rtl/issue_picker.sv
// Lowest-index-first priority encoder shared by the issue queues.
module issue_picker #(
    parameter int DP = 4,
    parameter int IW = $clog2(DP)
) (
    input  logic [DP-1:0] ready,
    output logic          pick_vaild,
    output logic [IW-1:0] pick_idx
);

    always_comb begin
        pick_vaild = |ready;
        pick_idx   = '0;
        for (int i = DP - 1; i >= 0; i--) begin
            if (ready[i]) pick_idx = IW'(i);
        end
    end

endmodule

// File: rtl/alu_issue.sv
// Age-ordered ALU issue buffer: tracks operand readiness, issues the oldest ready op
// per cycle and registers its operands for the single-cycle ALU.
module alu_issue
    import alu_pkg::*;
#(
    parameter int DP = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              flush,
    input  logic              alu_dispat_vaild,
    output logic              alu_dispat_ready,
    input  logic [DISP_W-1:0] alu_dispat_info,
    input  logic [NPR-1:0]    wbLog_qout,
    output logic [PR_W-1:0]   alu_rs1_addr,
    output logic [PR_W-1:0]   alu_rs2_addr,
    input  logic [63:0]       alu_rs1_data,
    input  logic [63:0]       alu_rs2_data,
    output logic              alu_execute_vaild,
    output logic [EXEC_W-1:0] alu_execute_info
);

    localparam int CW = $clog2(DP + 1);
    localparam int IW = $clog2(DP);

    iq_entry_t     q   [DP];
    iq_entry_t     q_n [DP];
    logic [CW-1:0] count;
    logic [CW-1:0] count_n;
    logic [CW-1:0] wr_idx;
    logic [DP-1:0] rdy;
    logic          pick_vaild;
    logic [IW-1:0] pick_idx;
    logic          enq;
    logic          iss;
    disp_info_t    new_op;
    disp_info_t    pick_op;
    exec_info_t    exec_n;

    assign new_op = disp_info_t'(alu_dispat_info);

    always_comb begin
        for (int i = 0; i < DP; i++) begin
            rdy[i] = q[i].valid & reg_ok(wbLog_qout, q[i].op.rs1)
                   & (q[i].op.rs2_is_imm | reg_ok(wbLog_qout, q[i].op.rs2));
        end
    end

    issue_picker #(.DP(DP), .IW(IW)) u_picker (
        .ready      (rdy),
        .pick_vaild (pick_vaild),
        .pick_idx   (pick_idx)
    );

    assign pick_op          = q[pick_idx].op;
    assign alu_rs1_addr     = pick_op.rs1;
    assign alu_rs2_addr     = pick_op.rs2;
    // Deliberately ignores a same-cycle issue so ready never depends on the wakeup path.
    assign alu_dispat_ready = (count != CW'(DP));
    assign iss              = pick_vaild & ~flush;
    assign enq              = alu_dispat_vaild & alu_dispat_ready & ~flush;
    assign wr_idx           = count - CW'(iss);
    assign count_n          = flush ? '0 : count + CW'(enq) - CW'(iss);

    always_comb begin
        exec_n.fun    = pick_op.fun;
        exec_n.rd0    = pick_op.rd0;
        exec_n.op1    = alu_rs1_data;
        exec_n.op2    = pick_op.rs2_is_imm ? pick_op.imm : alu_rs2_data;
        exec_n.is32w  = pick_op.is32w;
        exec_n.is_usi = pick_op.is_usi;
    end

    // NOTE: every entry gets its hold value first so the partial updates below never infer a latch.
    always_comb begin
        for (int i = 0; i < DP; i++) q_n[i] = q[i];
        if (iss) begin
            for (int i = 0; i < DP - 1; i++) begin
                if (i >= int'(pick_idx)) q_n[i] = q[i + 1];
            end
            q_n[DP-1] = '0;
        end
        if (enq) begin
            for (int i = 0; i < DP; i++) begin
                if (i == int'(wr_idx)) q_n[i] = '{valid: 1'b1, op: new_op};
            end
        end
        if (flush) begin
            for (int i = 0; i < DP; i++) q_n[i] = '0;
        end
    end

    // NOTE: state is updated with non-blocking assignments so all flops see pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count             <= '0;
            alu_execute_vaild <= 1'b0;
            alu_execute_info  <= '0;
            // NOTE: the queue is a handful of flops, not a RAM, so clearing whole entries is cheap and keeps X out of the payload.
            for (int i = 0; i < DP; i++) q[i] <= '0;
        end else begin
            count             <= count_n;
            q                 <= q_n;
            alu_execute_vaild <= iss;
            if (iss) alu_execute_info <= exec_n;
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: directed table, corner-case sequences and a randomized run
// against a queue-based reference model.
module tb_alu_issue;

    localparam int DP  = 4;
    localparam int PR  = 7;
    localparam int NPR = 128;

    typedef struct {
        int          f;
        int          rd;
        int          rs1;
        int          rs2;
        logic [63:0] imm;
        bit          ii;
        bit          w;
        bit          u;
    } mop_t;

    typedef struct {
        mop_t        m;
        logic [63:0] op1;
        logic [63:0] op2;
    } vec_t;

    logic           CLK = 1'b0;
    logic           RST;
    logic           flush;
    logic           alu_dispat_vaild;
    logic           alu_dispat_ready;
    logic [96:0]    alu_dispat_info;
    logic [NPR-1:0] wbLog_qout;
    logic [PR-1:0]  alu_rs1_addr;
    logic [PR-1:0]  alu_rs2_addr;
    logic [63:0]    alu_rs1_data;
    logic [63:0]    alu_rs2_data;
    logic           alu_execute_vaild;
    logic [145:0]   alu_execute_info;

    logic [63:0]    rf [NPR];
    int             total = 0;
    int             bad   = 0;

    always #5 CLK = ~CLK;

    assign alu_rs1_data = rf[alu_rs1_addr];
    assign alu_rs2_data = rf[alu_rs2_addr];

    alu_issue #(.DP(DP)) dut (
        .CLK               (CLK),
        .RST               (RST),
        .flush             (flush),
        .alu_dispat_vaild  (alu_dispat_vaild),
        .alu_dispat_ready  (alu_dispat_ready),
        .alu_dispat_info   (alu_dispat_info),
        .wbLog_qout        (wbLog_qout),
        .alu_rs1_addr      (alu_rs1_addr),
        .alu_rs2_addr      (alu_rs2_addr),
        .alu_rs1_data      (alu_rs1_data),
        .alu_rs2_data      (alu_rs2_data),
        .alu_execute_vaild (alu_execute_vaild),
        .alu_execute_info  (alu_execute_info)
    );

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [8:0] fun_of(input mop_t m);
        logic [8:0] fun;
        fun = 9'h100 >> m.f;
        return fun;
    endfunction

    function automatic logic [96:0] mk_info(input mop_t m);
        return {fun_of(m), PR'(m.rd), PR'(m.rs1), PR'(m.rs2), m.imm, m.ii, m.w, m.u};
    endfunction

    function automatic logic [145:0] exp_info(input mop_t m, input logic [63:0] op1, input logic [63:0] op2);
        return {fun_of(m), PR'(m.rd), op1, op2, m.w, m.u};
    endfunction

    function automatic bit op_ready(input mop_t m);
        return (m.rs1 == 0 || wbLog_qout[m.rs1]) && (m.ii || m.rs2 == 0 || wbLog_qout[m.rs2]);
    endfunction

    task automatic disp(input mop_t m);
        alu_dispat_vaild = 1'b1;
        alu_dispat_info  = mk_info(m);
        tick();
        alu_dispat_vaild = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t        vt [5];
        mop_t        ma, mb, mx, mf, mn, mr;
        mop_t        fill [4];
        mop_t        mq [$];
        int          seen;

        RST = 1'b1; flush = 1'b0; alu_dispat_vaild = 1'b0; alu_dispat_info = '0; wbLog_qout = '0;
        for (int i = 0; i < NPR; i++) rf[i] = 64'hA5A5_0000_0000_0000 | 64'(i);
        rf[0] = 64'd0; rf[2] = 64'd100; rf[3] = 64'd10; rf[4] = 64'd7; rf[5] = 64'hDEAD;
        rf[9] = 64'h99; rf[126] = 64'd1; rf[127] = 64'h8000_0000_0000_0000;

        // ---- reset state ----
        repeat (2) @(posedge CLK);
        #1;
        check("rst vaild", alu_execute_vaild, 1'b0);
        check("rst info", alu_execute_info, 146'd0);
        RST = 1'b0;
        #1;
        check("rst ready", alu_dispat_ready, 1'b1);
        tick();

        // ---- table: single ops, 2-cycle latency, field mapping ----
        wbLog_qout[2] = 1'b1; wbLog_qout[3] = 1'b1; wbLog_qout[4] = 1'b1;
        wbLog_qout[126] = 1'b1; wbLog_qout[127] = 1'b1;
        vt[0] = '{m: '{f:0, rd:5,   rs1:3,   rs2:4,   imm:64'd0, ii:0, w:0, u:0}, op1: 64'd10, op2: 64'd7};
        vt[1] = '{m: '{f:1, rd:6,   rs1:2,   rs2:5,   imm:64'hFFFF_FFFF_FFFF_FFFF, ii:1, w:1, u:0},
                  op1: 64'd100, op2: 64'hFFFF_FFFF_FFFF_FFFF};
        vt[2] = '{m: '{f:2, rd:7,   rs1:0,   rs2:4,   imm:64'd3, ii:0, w:0, u:1}, op1: 64'd0, op2: 64'd7};
        vt[3] = '{m: '{f:5, rd:8,   rs1:3,   rs2:0,   imm:64'd0, ii:0, w:1, u:1}, op1: 64'd10, op2: 64'd0};
        vt[4] = '{m: '{f:8, rd:127, rs1:127, rs2:126, imm:64'd0, ii:0, w:0, u:0},
                  op1: 64'h8000_0000_0000_0000, op2: 64'd1};
        for (int k = 0; k < 5; k++) begin
            disp(vt[k].m);
            check($sformatf("tbl%0d early", k), alu_execute_vaild, 1'b0);
            tick();
            check($sformatf("tbl%0d vaild", k), alu_execute_vaild, 1'b1);
            check($sformatf("tbl%0d info", k), alu_execute_info, exp_info(vt[k].m, vt[k].op1, vt[k].op2));
            check($sformatf("tbl%0d count", k), dut.count, 0);
        end
        tick();

        // ---- younger ready op bypasses older blocked op ----
        ma = '{f:0, rd:10, rs1:9, rs2:0, imm:64'd0, ii:0, w:0, u:0};
        mb = '{f:7, rd:11, rs1:3, rs2:4, imm:64'd0, ii:0, w:0, u:0};
        disp(ma);
        disp(mb);
        check("age no-issue", alu_execute_vaild, 1'b0);
        tick();
        check("age B vaild", alu_execute_vaild, 1'b1);
        check("age B info", alu_execute_info, exp_info(mb, 64'd10, 64'd7));
        wbLog_qout[9] = 1'b1;
        tick();
        check("age A vaild", alu_execute_vaild, 1'b1);
        check("age A info", alu_execute_info, exp_info(ma, 64'h99, 64'd0));
        tick();
        check("age idle", alu_execute_vaild, 1'b0);
        check("age count", dut.count, 0);

        // ---- full queue ----
        for (int k = 0; k < 4; k++) begin
            fill[k] = '{f:k, rd:20 + k, rs1:20 + k, rs2:0, imm:64'd0, ii:0, w:0, u:0};
            rf[20 + k] = 64'h2000 + 64'(k);
        end
        for (int k = 0; k < 4; k++) disp(fill[k]);
        check("full ready", alu_dispat_ready, 1'b0);
        mx = '{f:6, rd:30, rs1:0, rs2:0, imm:64'd0, ii:0, w:0, u:0};
        disp(mx);
        check("full no-issue", alu_execute_vaild, 1'b0);
        check("full count", dut.count, 4);
        wbLog_qout[20] = 1'b1;
        tick();
        check("full e0 vaild", alu_execute_vaild, 1'b1);
        check("full e0 info", alu_execute_info, exp_info(fill[0], 64'h2000, 64'd0));
        check("full ready back", alu_dispat_ready, 1'b1);
        wbLog_qout[21] = 1'b1; wbLog_qout[22] = 1'b1; wbLog_qout[23] = 1'b1;
        for (int k = 1; k < 4; k++) begin
            tick();
            check($sformatf("full e%0d info", k), alu_execute_info,
                  exp_info(fill[k], 64'h2000 + 64'(k), 64'd0));
        end
        tick();
        check("full 5th dropped", alu_execute_vaild, 1'b0);

        // ---- flush with a ready entry and a concurrent dispatch ----
        for (int k = 0; k < 3; k++) begin
            mn = '{f:0, rd:40 + k, rs1:40 + k, rs2:0, imm:64'd0, ii:0, w:0, u:0};
            disp(mn);
        end
        mf = '{f:0, rd:50, rs1:0, rs2:0, imm:64'd0, ii:0, w:0, u:0};
        wbLog_qout[41] = 1'b1;
        flush = 1'b1;
        disp(mf);
        flush = 1'b0;
        check("flush vaild", alu_execute_vaild, 1'b0);
        check("flush count", dut.count, 0);
        check("flush ready", alu_dispat_ready, 1'b1);
        wbLog_qout[40] = 1'b1; wbLog_qout[42] = 1'b1;
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (alu_execute_vaild) seen++;
        end
        check("flush nothing issues", seen, 0);

        // ---- asynchronous reset mid-operation ----
        mn = '{f:3, rd:60, rs1:60, rs2:0, imm:64'd0, ii:0, w:0, u:0};
        mr = '{f:4, rd:61, rs1:3,  rs2:4, imm:64'd0, ii:0, w:1, u:1};
        disp(mn);
        disp(mr);
        tick();
        check("arst pre vaild", alu_execute_vaild, 1'b1);
        #2 RST = 1'b1;
        #1;
        check("arst vaild", alu_execute_vaild, 1'b0);
        check("arst info", alu_execute_info, 146'd0);
        check("arst count", dut.count, 0);
        #2 RST = 1'b0;
        tick();
        check("arst ready", alu_dispat_ready, 1'b1);
        wbLog_qout[60] = 1'b1;
        seen = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (alu_execute_vaild) seen++;
        end
        check("arst queue empty", seen, 0);

        // ---- randomized run against the reference queue ----
        wbLog_qout = '0;
        for (int i = 1; i < NPR; i++) rf[i] = {$urandom, $urandom};
        for (int c = 0; c < 400; c++) begin
            mop_t        m;
            int          pick;
            bit          exp_v;
            bit          rdy_exp;
            logic [145:0] exp_x;
            m.f   = int'($urandom_range(0, 8));
            m.rd  = int'($urandom_range(0, 127));
            m.rs1 = int'($urandom_range(0, 15));
            m.rs2 = int'($urandom_range(0, 15));
            m.imm = {$urandom, $urandom};
            m.ii  = bit'($urandom_range(0, 1));
            m.w   = bit'($urandom_range(0, 1));
            m.u   = bit'($urandom_range(0, 1));
            alu_dispat_vaild = ($urandom_range(0, 99) < 60);
            alu_dispat_info  = mk_info(m);
            flush            = ($urandom_range(0, 99) < 3);
            if ($urandom_range(0, 99) < 30) wbLog_qout[$urandom_range(1, 15)] = 1'b1;
            if (c % 50 == 49) wbLog_qout = '0;
            #1;
            rdy_exp = (mq.size() != DP);
            check("rnd ready", alu_dispat_ready, rdy_exp);
            pick  = -1;
            exp_x = '0;
            for (int i = 0; i < mq.size(); i++) begin
                if (op_ready(mq[i])) begin
                    pick = i;
                    break;
                end
            end
            exp_v = (pick >= 0) && !flush;
            if (flush) begin
                mq.delete();
            end else begin
                if (exp_v) begin
                    exp_x = exp_info(mq[pick], rf[mq[pick].rs1], mq[pick].ii ? mq[pick].imm : rf[mq[pick].rs2]);
                    mq.delete(pick);
                end
                if (alu_dispat_vaild && rdy_exp) mq.push_back(m);
            end
            tick();
            check("rnd vaild", alu_execute_vaild, exp_v);
            if (exp_v) check("rnd info", alu_execute_info, exp_x);
        end
        alu_dispat_vaild = 1'b0;
        flush = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
